// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types for the request unit.
package cpu_types_pkg;
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      DATA = 2'd1,
      HALT = 2'd2
   } reqstate_t;
endpackage

// File: rtl/request_unit_if.sv
// request_unit_if: bundles the request unit pins for the core and for test harnesses.
interface request_unit_if #(
   parameter int CNT_W = 32
) (
   input logic CLK,
   input logic nRST
);
   logic             ihit;
   logic             dhit;
   logic             cu_dREN;
   logic             cu_dWEN;
   logic             cu_halt;
   logic             imemREN;
   logic             dmemREN;
   logic             dmemWEN;
   logic             pc_en;
   logic             halt;
   logic             err_timeout;
   logic [CNT_W-1:0] instr_cnt;
   logic [CNT_W-1:0] stall_cnt;
   modport ru (
      input  CLK, nRST, ihit, dhit, cu_dREN, cu_dWEN, cu_halt,
      output imemREN, dmemREN, dmemWEN, pc_en, halt, err_timeout, instr_cnt, stall_cnt
   );
   modport tb (
      input  CLK, nRST, imemREN, dmemREN, dmemWEN, pc_en, halt, err_timeout, instr_cnt, stall_cnt,
      output ihit, dhit, cu_dREN, cu_dWEN, cu_halt
   );
endinterface

// File: rtl/perf_counter.sv
// perf_counter: free-running event counter that wraps modulo 2^CNT_W.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) count <= '0;
      else if (inc) count <= count + CNT_W'(1);
   end
endmodule

// File: rtl/request_unit.sv
// request_unit: sequences fetch, optional data access and PC advance per instruction.
module request_unit
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             cu_dREN,
   input  logic             cu_dWEN,
   input  logic             cu_halt,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pc_en,
   output logic             halt,
   output logic             err_timeout,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   reqstate_t state, next_state;
   logic          mem_op, issue_data, data_wait, instr_inc, stall_inc;
   logic [TW-1:0] tmo;

   assign mem_op     = cu_dREN || cu_dWEN;
   assign issue_data = (state == RUN) && ihit && !cu_halt && mem_op;
   assign data_wait  = (state == DATA) && !dhit;
   assign imemREN    = (state == RUN);

   always_comb begin
      next_state = state;
      pc_en      = 1'b0;
      instr_inc  = 1'b0;
      stall_inc  = 1'b0;
      if (state == RUN) begin
         stall_inc = !ihit;
         if (ihit) begin
            next_state = cu_halt ? HALT : mem_op ? DATA : RUN;
            pc_en      = !cu_halt && !mem_op;
            instr_inc  = cu_halt || !mem_op;
         end
      end else if (state == DATA) begin
         next_state = dhit ? RUN : DATA;
         pc_en      = dhit;
         instr_inc  = dhit;
         stall_inc  = !dhit;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= RUN;
         dmemREN     <= 1'b0;
         dmemWEN     <= 1'b0;
         halt        <= 1'b0;
         err_timeout <= 1'b0;
         tmo         <= '0;
      end else begin
         state <= next_state;
         halt  <= (next_state == HALT);
         if (issue_data) begin
            dmemWEN <= cu_dWEN;
            dmemREN <= cu_dREN && !cu_dWEN;
            tmo     <= '0;
         end else if ((state == DATA) && dhit) begin
            dmemWEN <= 1'b0;
            dmemREN <= 1'b0;
         end else if (data_wait && (tmo != TW'(TIMEOUT_CYC))) begin
            tmo <= tmo + TW'(1);
         end
         // err latches on the wait that carries tmo up to the limit
         if (data_wait && (tmo >= TW'(TIMEOUT_CYC - 1))) err_timeout <= 1'b1;
      end
   end

   perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (instr_inc),
      .count (instr_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (stall_inc),
      .count (stall_cnt)
   );
endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_request_unit;
   logic CLK = 1'b0;
   logic nRST = 1'b0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      string       tag;
      logic [5:0]  bits;
      logic [31:0] ic;
      logic [31:0] sc;
   } exp_t;

   exp_t q[$];

   always #5 CLK = ~CLK;

   request_unit_if #(.CNT_W(32)) ruif (.CLK(CLK), .nRST(nRST));

   request_unit #(.TIMEOUT_CYC(255), .CNT_W(32)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ihit        (ruif.ihit),
      .dhit        (ruif.dhit),
      .cu_dREN     (ruif.cu_dREN),
      .cu_dWEN     (ruif.cu_dWEN),
      .cu_halt     (ruif.cu_halt),
      .imemREN     (ruif.imemREN),
      .dmemREN     (ruif.dmemREN),
      .dmemWEN     (ruif.dmemWEN),
      .pc_en       (ruif.pc_en),
      .halt        (ruif.halt),
      .err_timeout (ruif.err_timeout),
      .instr_cnt   (ruif.instr_cnt),
      .stall_cnt   (ruif.stall_cnt)
   );

   // Expected bits are {imemREN, dmemREN, dmemWEN, pc_en, halt, err_timeout}.
   task automatic cyc(input string tag, input logic rn, input logic ih, input logic dh,
                      input logic dr, input logic dw, input logic hl,
                      input logic [5:0] eb, input int ic, input int sc);
      exp_t e;
      @(posedge CLK);
      #1;
      nRST         = rn;
      ruif.ihit    = ih;
      ruif.dhit    = dh;
      ruif.cu_dREN = dr;
      ruif.cu_dWEN = dw;
      ruif.cu_halt = hl;
      e.tag  = tag;
      e.bits = eb;
      e.ic   = ic;
      e.sc   = sc;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [5:0] act;
      forever begin
         @(negedge CLK);
         if (q.size() != 0) begin
            e   = q.pop_front();
            act = {ruif.imemREN, ruif.dmemREN, ruif.dmemWEN, ruif.pc_en, ruif.halt, ruif.err_timeout};
            checks++;
            if (act !== e.bits || ruif.instr_cnt !== e.ic || ruif.stall_cnt !== e.sc) begin
               failures++;
               $display("FAIL %s: got bits=%b ic=%0d sc=%0d, want bits=%b ic=%0d sc=%0d",
                        e.tag, act, ruif.instr_cnt, ruif.stall_cnt, e.bits, e.ic, e.sc);
            end
         end
      end
   end

   initial begin : driver
      ruif.ihit    = 1'b0;
      ruif.dhit    = 1'b0;
      ruif.cu_dREN = 1'b0;
      ruif.cu_dWEN = 1'b0;
      ruif.cu_halt = 1'b0;
      cyc("reset",    0, 0, 0, 0, 0, 0, 6'b100000, 0, 0);
      cyc("alu1",     1, 1, 0, 0, 0, 0, 6'b100100, 0, 0);
      cyc("alu2",     1, 1, 0, 0, 0, 0, 6'b100100, 1, 0);
      cyc("alu3",     1, 1, 0, 0, 0, 0, 6'b100100, 2, 0);
      cyc("alu_done", 1, 0, 0, 0, 0, 0, 6'b100000, 3, 0);
      cyc("ld_issue", 1, 1, 0, 1, 0, 0, 6'b100000, 3, 1);
      cyc("ld_w1",    1, 1, 0, 0, 0, 0, 6'b010000, 3, 1);
      cyc("ld_w2",    1, 1, 0, 0, 0, 0, 6'b010000, 3, 2);
      cyc("ld_hit",   1, 0, 1, 0, 0, 0, 6'b010100, 3, 3);
      cyc("ld_done",  1, 0, 0, 0, 0, 0, 6'b100000, 4, 3);
      cyc("st_issue", 1, 1, 0, 1, 1, 0, 6'b100000, 4, 4);
      cyc("st_hit",   1, 0, 1, 0, 0, 0, 6'b001100, 4, 4);
      cyc("st_done",  1, 0, 1, 0, 0, 0, 6'b100000, 5, 4);
      cyc("to_issue", 1, 1, 0, 1, 0, 0, 6'b100000, 5, 5);
      for (int w = 1; w <= 300; w++)
         cyc($sformatf("to_wait%0d", w), 1, 0, 0, 0, 0, 0, {5'b01000, w >= 256}, 5, 4 + w);
      cyc("to_hit",   1, 0, 1, 0, 0, 0, 6'b010101, 5, 305);
      cyc("to_done",  1, 0, 0, 0, 0, 0, 6'b100001, 6, 305);
      cyc("hl_issue", 1, 1, 0, 0, 1, 1, 6'b100001, 6, 306);
      for (int i = 0; i < 20; i++)
         cyc($sformatf("hl_hold%0d", i), 1, 1, 1, 1, 0, 0, 6'b000011, 7, 306);
      cyc("rst_halt", 0, 0, 0, 0, 0, 0, 6'b100000, 0, 0);
      cyc("md_issue", 1, 1, 0, 0, 1, 0, 6'b100000, 0, 0);
      cyc("md_wait",  1, 0, 0, 0, 0, 0, 6'b001000, 0, 0);
      cyc("md_rst",   0, 0, 0, 0, 0, 0, 6'b100000, 0, 0);
      cyc("md_idle",  1, 0, 0, 0, 0, 0, 6'b100000, 0, 0);
      cyc("md_alu",   1, 1, 0, 0, 0, 0, 6'b100100, 0, 1);
      for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge CLK);
      @(posedge CLK);
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
